// File: rtl/alarm_controller.sv
// Alarm clock controller: stores the alarm time, rings on an exact minute
// match, and handles snooze, stop, timeout and the sticky missed flag.
module alarm_controller #(
  parameter int SNOOZE_SEC   = 300,
  parameter int RING_TIMEOUT = 60,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       alarm_enable,
  input  logic       set_alarm,
  input  logic [4:0] alarm_hr_in,
  input  logic [5:0] alarm_min_in,
  input  logic       snooze,
  input  logic       stop,
  output logic       alarm_on,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic [1:0] snooze_count,
  output logic       missed,
  output logic [1:0] state
);

  localparam int RING_W = (RING_TIMEOUT > 1) ? $clog2(RING_TIMEOUT) : 1;
  localparam int SNZ_W  = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SEC - 1);
  localparam logic [1:0]        SNZ_MAX   = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } state_t;

  state_t            state_reg;
  logic [RING_W-1:0] ring_cnt_reg;
  logic [SNZ_W-1:0]  snz_cnt_reg;
  logic              load_ok;
  logic              time_match;

  assign load_ok    = (alarm_hr_in <= 5'd23) && (alarm_min_in <= 6'd59);
  // Requiring seconds==0 makes each alarm minute fire at most once.
  assign time_match = (hours == alarm_hours) && (minutes == alarm_minutes) &&
                      (seconds == 6'd0);
  assign state      = state_reg;

  always_ff @(posedge clk_1Hz) begin
    if (reset) begin
      state_reg     <= IDLE;
      alarm_on      <= 1'b0;
      alarm_hours   <= 5'd0;
      alarm_minutes <= 6'd0;
      snooze_count  <= 2'd0;
      missed        <= 1'b0;
      ring_cnt_reg  <= '0;
      snz_cnt_reg   <= '0;
    end else begin
      if (set_alarm || stop)
        missed <= 1'b0;
      if (set_alarm && load_ok) begin
        alarm_hours   <= alarm_hr_in;
        alarm_minutes <= alarm_min_in;
      end

      // Disable and reprogramming both abort any event in progress.
      if (!alarm_enable || set_alarm) begin
        state_reg <= IDLE;
        alarm_on  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (time_match) begin
              state_reg    <= RINGING;
              alarm_on     <= 1'b1;
              ring_cnt_reg <= '0;
              snooze_count <= 2'd0;
              missed       <= 1'b0;
            end
          end
          RINGING: begin
            if (stop) begin
              state_reg <= IDLE;
              alarm_on  <= 1'b0;
            end else if (snooze && (snooze_count < SNZ_MAX)) begin
              state_reg    <= SNOOZE;
              alarm_on     <= 1'b0;
              snz_cnt_reg  <= SNZ_LOAD;
              snooze_count <= snooze_count + 2'd1;
            end else if (ring_cnt_reg == RING_LAST) begin
              state_reg <= IDLE;
              alarm_on  <= 1'b0;
              missed    <= 1'b1;
            end else begin
              ring_cnt_reg <= ring_cnt_reg + RING_W'(1);
            end
          end
          SNOOZE: begin
            if (stop) begin
              state_reg <= IDLE;
              alarm_on  <= 1'b0;
            end else if (snz_cnt_reg == '0) begin
              state_reg    <= RINGING;
              alarm_on     <= 1'b1;
              ring_cnt_reg <= '0;
            end else begin
              snz_cnt_reg <= snz_cnt_reg - SNZ_W'(1);
            end
          end
          default: begin
            state_reg <= IDLE;
            alarm_on  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios plus a random
// run against a timestamp-based reference model.
module tb_alarm_controller;

  localparam int SNOOZE_SEC   = 300;
  localparam int RING_TIMEOUT = 60;
  localparam int MAX_SNOOZE   = 3;
  localparam int T0630        = 6 * 3600 + 30 * 60;

  logic       clk_1Hz = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] seconds = '0;
  logic [5:0] minutes = '0;
  logic [4:0] hours = '0;
  logic       alarm_enable = 1'b0;
  logic       set_alarm = 1'b0;
  logic [4:0] alarm_hr_in = '0;
  logic [5:0] alarm_min_in = '0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic       alarm_on;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic [1:0] snooze_count;
  logic       missed;
  logic [1:0] state;

  alarm_controller #(
    .SNOOZE_SEC(SNOOZE_SEC),
    .RING_TIMEOUT(RING_TIMEOUT),
    .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk_1Hz(clk_1Hz),
    .reset(reset),
    .seconds(seconds),
    .minutes(minutes),
    .hours(hours),
    .alarm_enable(alarm_enable),
    .set_alarm(set_alarm),
    .alarm_hr_in(alarm_hr_in),
    .alarm_min_in(alarm_min_in),
    .snooze(snooze),
    .stop(stop),
    .alarm_on(alarm_on),
    .alarm_hours(alarm_hours),
    .alarm_minutes(alarm_minutes),
    .snooze_count(snooze_count),
    .missed(missed),
    .state(state)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  int errors = 0;
  int checks = 0;
  int tod = 0;

  // Reference model: mode 0 idle, 1 ringing, 2 snoozing; timing kept as
  // absolute cycle stamps rather than counters.
  int m_mode = 0, m_hr = 0, m_min = 0, m_sc = 0;
  bit m_missed = 1'b0;
  int m_cyc = 0, ring_start = 0, wake_at = 0;

  logic [16:0] dut_vec;
  assign dut_vec = {state, alarm_on, alarm_hours, alarm_minutes, snooze_count, missed};

  function automatic logic [16:0] exp_vec();
    return {2'(m_mode), (m_mode == 1), 5'(m_hr), 6'(m_min), 2'(m_sc), m_missed};
  endfunction

  task automatic drive_time();
    hours   = 5'(tod / 3600);
    minutes = 6'((tod / 60) % 60);
    seconds = 6'(tod % 60);
  endtask

  task automatic set_time(input int t);
    tod = (t + 86400) % 86400;
    drive_time();
  endtask

  task automatic model_step();
    bit match;
    if (reset) begin
      m_mode = 0; m_hr = 0; m_min = 0; m_sc = 0; m_missed = 1'b0;
    end else begin
      match = (tod / 3600 == m_hr) && ((tod / 60) % 60 == m_min) && (tod % 60 == 0);
      if (set_alarm || stop) m_missed = 1'b0;
      if (set_alarm && alarm_hr_in <= 23 && alarm_min_in <= 59) begin
        m_hr = alarm_hr_in; m_min = alarm_min_in;
      end
      if (!alarm_enable || set_alarm) m_mode = 0;
      else if (m_mode == 0) begin
        if (match) begin
          m_mode = 1; ring_start = m_cyc; m_sc = 0; m_missed = 1'b0;
        end
      end else if (stop) m_mode = 0;
      else if (m_mode == 1) begin
        if (snooze && m_sc < MAX_SNOOZE) begin
          m_mode = 2; wake_at = m_cyc + SNOOZE_SEC; m_sc++;
        end else if (m_cyc - ring_start >= RING_TIMEOUT) begin
          m_mode = 0; m_missed = 1'b1;
        end
      end else if (m_cyc >= wake_at) begin
        m_mode = 1; ring_start = m_cyc;
      end
    end
    m_cyc++;
  endtask

  // One clock: model consumes the inputs, DUT samples them, time advances.
  task automatic tick();
    model_step();
    @(posedge clk_1Hz);
    @(negedge clk_1Hz);
    tod = (tod + 1) % 86400;
    drive_time();
  endtask

  task automatic load_alarm(input int h, input int m);
    set_alarm = 1'b1; alarm_hr_in = 5'(h); alarm_min_in = 6'(m);
    tick();
    set_alarm = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    if (dut_vec !== 17'd0) begin
      errors++; $display("FAIL reset_state got=%h want=%h", dut_vec, 17'd0);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_model got=%h want=%h", dut_vec, exp_vec());
    end
    checks++;
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_trigger_stop();
    set_time(6 * 3600);
    load_alarm(6, 30);
    if (alarm_hours !== 5'd6 || alarm_minutes !== 6'd30) begin
      errors++; $display("FAIL load_0630 got=%0d:%0d want=6:30", alarm_hours, alarm_minutes);
    end
    checks++;
    alarm_enable = 1'b1;
    set_time(T0630 - 1);
    tick();
    if (state !== 2'b00 || alarm_on !== 1'b0) begin
      errors++; $display("FAIL pre_trigger got state=%b on=%b want state=00 on=0", state, alarm_on);
    end
    checks++;
    tick();
    if (state !== 2'b01 || alarm_on !== 1'b1) begin
      errors++; $display("FAIL trigger got state=%b on=%b want state=01 on=1", state, alarm_on);
    end
    checks++;
    while (tod < T0630 + 5) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL ringing got=%h want=%h", dut_vec, exp_vec());
      end
      checks++;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    if (state !== 2'b00 || alarm_on !== 1'b0) begin
      errors++; $display("FAIL stop got state=%b on=%b want state=00 on=0", state, alarm_on);
    end
    checks++;
    while (tod != T0630 + 61) begin
      tick();
      if (alarm_on !== 1'b0 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL no_refire got=%h want=%h", dut_vec, exp_vec());
      end
      checks++;
    end
    $display("test_trigger_stop done");
  endtask

  task automatic test_timeout();
    int cnt, guard;
    set_time(T0630);
    tick();
    cnt = (alarm_on === 1'b1) ? 1 : 0;
    guard = 0;
    while (alarm_on === 1'b1 && guard < 200) begin
      tick();
      guard++;
      if (alarm_on === 1'b1) cnt++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL timeout_model got=%h want=%h", dut_vec, exp_vec());
      end
      checks++;
    end
    if (cnt !== RING_TIMEOUT || state !== 2'b00 || missed !== 1'b1) begin
      errors++; $display("FAIL timeout got ring=%0d state=%b missed=%b want ring=60 state=00 missed=1",
                         cnt, state, missed);
    end
    checks++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    if (missed !== 1'b0) begin
      errors++; $display("FAIL stop_clears_missed got=%b want=0", missed);
    end
    checks++;
    $display("test_timeout done");
  endtask

  task automatic test_snooze();
    int gap, guard, cnt;
    set_time(T0630);
    tick();
    for (int k = 1; k <= MAX_SNOOZE; k++) begin
      snooze = 1'b1;
      tick();
      snooze = 1'b0;
      if (state !== 2'b10 || snooze_count !== 2'(k)) begin
        errors++; $display("FAIL snooze_enter got state=%b count=%0d want state=10 count=%0d",
                           state, snooze_count, k);
      end
      checks++;
      gap = 1;
      guard = 0;
      while (alarm_on === 1'b0 && guard < 1000) begin
        tick();
        guard++;
        if (alarm_on === 1'b0) gap++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL snooze_model got=%h want=%h", dut_vec, exp_vec());
        end
        checks++;
      end
      if (gap !== SNOOZE_SEC || state !== 2'b01) begin
        errors++; $display("FAIL snooze_gap got gap=%0d state=%b want gap=300 state=01", gap, state);
      end
      checks++;
    end
    cnt = 1;
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    if (alarm_on === 1'b1) cnt++;
    if (state !== 2'b01 || snooze_count !== 2'd3) begin
      errors++; $display("FAIL fourth_snooze got state=%b count=%0d want state=01 count=3",
                         state, snooze_count);
    end
    checks++;
    guard = 0;
    while (alarm_on === 1'b1 && guard < 200) begin
      tick();
      guard++;
      if (alarm_on === 1'b1) cnt++;
    end
    if (cnt !== RING_TIMEOUT || state !== 2'b00 || missed !== 1'b1) begin
      errors++; $display("FAIL final_timeout got ring=%0d state=%b missed=%b want ring=60 state=00 missed=1",
                         cnt, state, missed);
    end
    checks++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    $display("test_snooze done");
  endtask

  task automatic test_conflicts();
    int guard;
    set_time(T0630);
    tick();
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    guard = 0;
    while (alarm_on !== 1'b1 && guard < 1000) begin
      tick();
      guard++;
    end
    if (alarm_on !== 1'b1) begin
      errors++; $display("FAIL rering got on=%b want on=1", alarm_on);
    end
    checks++;
    stop = 1'b1; snooze = 1'b1;
    tick();
    stop = 1'b0; snooze = 1'b0;
    if (state !== 2'b00 || snooze_count !== 2'd1) begin
      errors++; $display("FAIL stop_and_snooze got state=%b count=%0d want state=00 count=1",
                         state, snooze_count);
    end
    checks++;
    load_alarm(25, 10);
    if (alarm_hours !== 5'd6 || alarm_minutes !== 6'd30 || state !== 2'b00) begin
      errors++; $display("FAIL invalid_load got %0d:%0d state=%b want 6:30 state=00",
                         alarm_hours, alarm_minutes, state);
    end
    checks++;
    set_time(T0630);
    tick();
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    repeat (5) tick();
    load_alarm(7, 0);
    if (state !== 2'b00 || alarm_on !== 1'b0 || alarm_hours !== 5'd7 || alarm_minutes !== 6'd0) begin
      errors++; $display("FAIL set_in_snooze got state=%b on=%b %0d:%0d want state=00 on=0 7:0",
                         state, alarm_on, alarm_hours, alarm_minutes);
    end
    checks++;
    load_alarm(6, 30);
    $display("test_conflicts done");
  endtask

  task automatic test_enable();
    alarm_enable = 1'b0;
    set_time(T0630);
    tick();
    if (state !== 2'b00 || alarm_on !== 1'b0) begin
      errors++; $display("FAIL disabled_match got state=%b on=%b want state=00 on=0", state, alarm_on);
    end
    checks++;
    alarm_enable = 1'b1;
    set_time(T0630);
    tick();
    tick();
    tick();
    if (state !== 2'b01) begin
      errors++; $display("FAIL enabled_ring got state=%b want 01", state);
    end
    checks++;
    alarm_enable = 1'b0;
    tick();
    if (state !== 2'b00 || alarm_on !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL enable_drop got=%h want=%h", dut_vec, exp_vec());
    end
    checks++;
    alarm_enable = 1'b1;
    $display("test_enable done");
  endtask

  task automatic test_reset_mid_snooze();
    set_time(T0630);
    tick();
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (dut_vec !== 17'd0) begin
      errors++; $display("FAIL reset_mid_snooze got=%h want=%h", dut_vec, 17'd0);
    end
    checks++;
    set_time(T0630 - 2);
    repeat (5) begin
      tick();
      if (alarm_on !== 1'b0 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL no_ring_after_reset got=%h want=%h", dut_vec, exp_vec());
      end
      checks++;
    end
    $display("test_reset_mid_snooze done");
  endtask

  task automatic test_random();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    alarm_enable = 1'b1;
    load_alarm($urandom_range(0, 23), $urandom_range(0, 59));
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 599) == 0);
      set_alarm    = ($urandom_range(0, 249) == 0);
      alarm_hr_in  = 5'($urandom_range(0, 31));
      alarm_min_in = 6'($urandom_range(0, 63));
      stop         = ($urandom_range(0, 59) == 0);
      snooze       = ($urandom_range(0, 7) == 0);
      alarm_enable = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 79) == 0) set_time(m_hr * 3600 + m_min * 60 - 1);
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
      checks++;
    end
    reset = 1'b0; set_alarm = 1'b0; stop = 1'b0; snooze = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    drive_time();
    test_reset();
    test_trigger_stop();
    test_timeout();
    test_snooze();
    test_conflicts();
    test_enable();
    test_reset_mid_snooze();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SNOOZE_SEC, 300, cycles spent in SNOOZE before re-ringing.
- RING_TIMEOUT, 60, cycles of unanswered ringing before giving up.
- MAX_SNOOZE, 3, snoozes allowed per alarm event.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_1Hz, in, 1, sole clock, 1 Hz tick from the clock divider; one cycle = one second.
- reset, in, 1, synchronous, active-high.
- seconds, in, 6, current time from the time counter, 0..59.
- minutes, in, 6, current time, 0..59.
- hours, in, 5, current time, 0..23.
- alarm_enable, in, 1, level; 0 disables the alarm.
- set_alarm, in, 1, load alarm_hr_in/alarm_min_in this cycle.
- alarm_hr_in, in, 5, alarm hour to load.
- alarm_min_in, in, 6, alarm minute to load.
- snooze, in, 1, snooze request, sampled each cycle.
- stop, in, 1, stop request, sampled each cycle.
- alarm_on, out, 1, buzzer drive; 1 iff state is RINGING.
- alarm_hours, out, 5, stored alarm hour.
- alarm_minutes, out, 6, stored alarm minute.
- snooze_count, out, 2, snoozes used in the current event.
- missed, out, 1, sticky; the alarm timed out unanswered.
- state, out, 2, IDLE=00, RINGING=01, SNOOZE=10; 11 is never produced.

REQ-003 The block SHALL use clk_1Hz as its only clock, and all outputs SHALL be registered.

Function
REQ-004 Alarm load: set_alarm=1 with alarm_hr_in<=23 and alarm_min_in<=59 SHALL load both registers at the edge.
REQ-005 Invalid load: set_alarm=1 with an out-of-range value SHALL leave both registers unchanged; the state effect of REQ-016 still applies.
REQ-006 Trigger: in IDLE, with alarm_enable=1, set_alarm=0, hours==alarm_hours, minutes==alarm_minutes and seconds==0, the state SHALL become RINGING at that edge.
REQ-007 The trigger SHALL set the ring counter to 0, set snooze_count to 0, and assert alarm_on in the same registered update.
REQ-008 Stop and snooze SHALL be ignored in IDLE.
REQ-009 RINGING, stop=1: the state SHALL go to IDLE. Stop has priority over snooze.
REQ-010 RINGING, snooze=1, stop=0, snooze_count<MAX_SNOOZE: the state SHALL go to SNOOZE, load the snooze counter with SNOOZE_SEC-1, and increment snooze_count.
REQ-011 RINGING, snooze=1, snooze_count==MAX_SNOOZE: snooze SHALL be ignored and the ring counter SHALL keep counting.
REQ-012 RINGING, no accepted request: the ring counter SHALL increment. When it equals RING_TIMEOUT-1, the state SHALL go to IDLE and missed SHALL be set. alarm_on is therefore high for exactly RING_TIMEOUT cycles.
REQ-013 SNOOZE: alarm_on SHALL be 0 and the snooze counter SHALL decrement each cycle. At 0, the state SHALL go to RINGING with the ring counter reset to 0. SNOOZE therefore lasts exactly SNOOZE_SEC cycles.
REQ-014 SNOOZE, stop=1: the state SHALL go to IDLE. Snooze in SNOOZE SHALL be ignored.
REQ-015 alarm_enable=0 SHALL force IDLE from any state at the next edge and SHALL block triggering.
REQ-016 set_alarm=1 in RINGING or SNOOZE SHALL force IDLE. In IDLE it SHALL suppress a same-cycle trigger.
REQ-017 Because triggering requires seconds==0, a given alarm minute SHALL fire at most once, and a stopped alarm SHALL NOT re-fire within that minute.
REQ-018 missed SHALL clear on a new trigger, on set_alarm=1, or on stop=1 in any state.
REQ-019 snooze_count SHALL hold its value in IDLE until the next trigger.
REQ-020 Counter widths SHALL be sized from SNOOZE_SEC and RING_TIMEOUT, and the counters SHALL never wrap.

Reset
REQ-021 reset=1 at an edge SHALL take priority over all inputs and set: state=IDLE, alarm_on=0, alarm_hours=0, alarm_minutes=0, snooze_count=0, missed=0, and both internal counters to 0.
REQ-022 reset asserted mid-RINGING or mid-SNOOZE SHALL abort the event, with no ringing after release until the next trigger.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Load 06:30, enable=1, time 06:29:59 -> 06:30:00: RINGING and alarm_on=1 after the 06:30:00 edge; stop at 06:30:05 -> IDLE, no re-ring through 06:31:00.
- Ringing, no input: alarm_on high exactly 60 cycles, then IDLE with missed=1; stop then clears missed.
- Snooze three times with SNOOZE_SEC=300: each gap is exactly 300 cycles of alarm_on=0; snooze_count reaches 3; a fourth snooze is ignored and timeout occurs 60 cycles after re-ring.
- stop and snooze together in RINGING -> IDLE and snooze_count unchanged; set_alarm 25:10 -> registers unchanged; set_alarm 07:00 during SNOOZE -> IDLE with 07:00 loaded.
- Match at 06:30:00 with enable=0 -> no ring; enable dropped mid-RINGING -> IDLE next edge.
- reset pulse mid-SNOOZE -> all outputs at reset values next edge, alarm_hours=0, no later ring at the old time.
